if_id_register: RTL and testbench
=================================

IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 Parameter NOP_WORD, default 32'h00000000; instruction word inserted on flush or reset.
REQ-002 Parameter CNT_W, default 16; width of the event counters.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PCAddResult  input  32  PC+4 from fetch.
REQ-006 Instruction  input  32  word read from instruction memory at the current PC.
REQ-007 Stall  input  1  hazard unit hold request; when high, the register SHALL keep its contents.
REQ-008 Flush  input  1  branch/jump squash request; when high, a bubble SHALL be inserted.
REQ-009 ID_PCAddResult  output  32  registered PC+4 for decode.
REQ-010 ID_Instruction  output  32  registered instruction for decode.
REQ-011 ID_Valid  output  1  high when the ID slot holds a real fetched instruction.
REQ-012 StallCount  output  CNT_W  cycles held by Stall (macro builds only).
REQ-013 FlushCount  output  CNT_W  bubbles inserted by Flush (macro builds only).

Function
REQ-014 Block SHALL be a one-stage register with 1-cycle latency: inputs sampled at edge N appear on outputs after edge N.
REQ-015 Per-edge priority SHALL be Reset > Flush > Stall > Load.
REQ-016 Load (no Reset/Flush/Stall): ID_PCAddResult<=PCAddResult, ID_Instruction<=Instruction, ID_Valid<=1.
REQ-017 Stall only: all outputs SHALL hold their previous values, including ID_Valid.
REQ-018 Flush (with or without Stall): ID_Instruction<=NOP_WORD, ID_PCAddResult<=0, ID_Valid<=0.
REQ-019 Slot state SHALL be EMPTY (ID_Valid=0) or FULL (ID_Valid=1); Load moves to FULL, Flush or Reset to EMPTY, Stall holds.
REQ-020 Stall while EMPTY SHALL keep the bubble; a stalled bubble SHALL NOT become valid.
REQ-021 Outputs SHALL be driven only from registers, with no combinational path from inputs to outputs.
REQ-022 Unknown (X) Stall or Flush is illegal; behaviour under X is unspecified.

Reset
REQ-023 On an edge with Reset=1: ID_PCAddResult=32'h00000000, ID_Instruction=NOP_WORD, ID_Valid=0, and both counters cleared to 0.
REQ-024 Reset asserted mid-stall or mid-flush SHALL override both; the first Load after Reset deasserts SHALL proceed normally.

Configuration
REQ-025 Macro IF_ID_PERF_COUNT_EN: when defined, StallCount and FlushCount ports and logic SHALL exist.
REQ-026 StallCount SHALL increment on each edge with Stall=1, Flush=0, Reset=0.
REQ-027 FlushCount SHALL increment on each edge with Flush=1, Reset=0.
REQ-028 Both counters SHALL saturate at all-ones rather than wrap.
REQ-029 When the macro is undefined, the counter ports and logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-030 Reset held 2 cycles, then PCAddResult=32'h4, Instruction=32'h8C010000 -> after the next edge: ID_PCAddResult=4, ID_Instruction=8C010000, ID_Valid=1.
REQ-031 Loaded 32'h20020005, then Stall=1 for 3 edges with changing inputs -> outputs stay at 20020005, ID_Valid=1; StallCount=3.
REQ-032 Flush=1 and Stall=1 on the same edge -> ID_Instruction=NOP_WORD, ID_PCAddResult=0, ID_Valid=0; FlushCount+1, StallCount unchanged.
REQ-033 Flush edge followed by Stall for 2 edges -> ID_Valid stays 0; next Load -> ID_Valid=1.
REQ-034 Reset=1 asserted during a stall -> outputs go to reset values on that edge; counters read 0.
REQ-035 Macro build with CNT_W=4 and Stall held 20 cycles -> StallCount=4'hF and holds there.

Source files
------------

// File: rtl/if_id_register.sv
// IF/ID pipeline register: one-cycle slot between fetch and decode with stall, flush and reset.
// Optional stall/flush event counters are built when IF_ID_PERF_COUNT_EN is defined.
module if_id_register #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PCAddResult,
    input  logic [31:0]      Instruction,
    input  logic             Stall,
    input  logic             Flush,
    output logic [31:0]      ID_PCAddResult,
    output logic [31:0]      ID_Instruction,
    output logic             ID_Valid
`ifdef IF_ID_PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e       state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Flush outranks Stall, so a squashed slot never survives as a held instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (Flush) begin
            state_d = EMPTY;
            pc_d    = '0;
            instr_d = NOP_WORD;
        end else if (!Stall) begin
            state_d = FULL;
            pc_d    = PCAddResult;
            instr_d = Instruction;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign ID_PCAddResult = pc_q;
    assign ID_Instruction = instr_q;
    assign ID_Valid       = (state_q == FULL);

`ifdef IF_ID_PERF_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Flush) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (Stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Scoreboard bench for if_id_register; counter checks are compiled in with IF_ID_PERF_COUNT_EN.
module tb_if_id_register;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCAddResult = '0;
    logic [31:0] Instruction = '0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] ID_PCAddResult;
    logic [31:0] ID_Instruction;
    logic        ID_Valid;
`ifdef IF_ID_PERF_COUNT_EN
    logic [15:0] StallCount, FlushCount;
    logic [3:0]  StallCount4, FlushCount4;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [64:0] sb[$];
    logic [64:0] exp;
    logic [31:0] m_pc, m_ins;
    logic        m_v;
    logic [15:0] m_sc, m_fc;
    logic [3:0]  m_sc4;

    if_id_register #(.NOP_WORD(NOP), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Instruction(Instruction),
        .Stall(Stall), .Flush(Flush), .ID_PCAddResult(ID_PCAddResult),
        .ID_Instruction(ID_Instruction), .ID_Valid(ID_Valid)
`ifdef IF_ID_PERF_COUNT_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

`ifdef IF_ID_PERF_COUNT_EN
    logic [31:0] pc4_unused, ins4_unused;
    logic        v4_unused;
    if_id_register #(.NOP_WORD(NOP), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Instruction(Instruction),
        .Stall(Stall), .Flush(Flush), .ID_PCAddResult(pc4_unused),
        .ID_Instruction(ins4_unused), .ID_Valid(v4_unused),
        .StallCount(StallCount4), .FlushCount(FlushCount4)
    );
`endif

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Applies one cycle of stimulus, advances the reference model and queues its expectation.
    task automatic drive(input logic r, input logic f, input logic s,
                         input logic [31:0] pc, input logic [31:0] ins);
        Reset = r; Flush = f; Stall = s; PCAddResult = pc; Instruction = ins;
        if (r) begin
            m_pc = '0; m_ins = NOP; m_v = 1'b0; m_sc = '0; m_fc = '0; m_sc4 = '0;
        end else if (f) begin
            m_pc = '0; m_ins = NOP; m_v = 1'b0;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end else if (s) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (m_sc4 != 4'hF) m_sc4 = m_sc4 + 4'd1;
        end else begin
            m_pc = pc; m_ins = ins; m_v = 1'b1;
        end
        sb.push_back({m_pc, m_ins, m_v});
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
            exp = sb.pop_front();
            checks++;
            if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
                failures++;
                $display("FAIL reset[%0d] got=%h want=%h", i, {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
            end
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (StallCount !== 16'd0 || FlushCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h want=0/0", StallCount, FlushCount);
        end
`endif
    endtask

    task automatic test_load();
        logic [31:0] pcs[4]  = '{32'h4, 32'h8, 32'hFFFFFFFC, 32'h0000_1234};
        logic [31:0] inss[4] = '{32'h8C010000, 32'h20020005, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, pcs[i], inss[i]);
            exp = sb.pop_front();
            checks++;
            if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
                failures++;
                $display("FAIL load[%0d] got=%h want=%h", i, {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        void'(sb.pop_front());
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h20020005);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h100 + i, 32'hA5A50000 + i);
            exp = sb.pop_front();
            checks++;
            if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h want=%h", i, {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
            end
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (StallCount !== m_sc) begin
            failures++;
            $display("FAIL stall_count got=%0d want=%0d", StallCount, m_sc);
        end
`endif
    endtask

    task automatic test_flush_stall();
        drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h11111111);
        exp = sb.pop_front();
        checks++;
        if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
            failures++;
            $display("FAIL flush_with_stall got=%h want=%h", {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (StallCount !== m_sc || FlushCount !== m_fc) begin
            failures++;
            $display("FAIL flush_counts got=%0d/%0d want=%0d/%0d", StallCount, FlushCount, m_sc, m_fc);
        end
`endif
    endtask

    task automatic test_bubble_stall();
        drive(1'b0, 1'b0, 1'b0, 32'h300, 32'h22222222);
        void'(sb.pop_front());
        drive(1'b0, 1'b1, 1'b0, 32'h304, 32'h33333333);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b0, 1'b0, 1'b1, 32'h308, 32'h44444444);
            else       drive(1'b0, 1'b0, 1'b0, 32'h30C, 32'h55555555);
            exp = sb.pop_front();
            checks++;
            if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
                failures++;
                $display("FAIL bubble_stall[%0d] got=%h want=%h", i, {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
            end
        end
    endtask

    task automatic test_reset_in_stall();
        drive(1'b0, 1'b0, 1'b1, 32'h400, 32'h66666666);
        void'(sb.pop_front());
        drive(1'b1, 1'b0, 1'b1, 32'h404, 32'h77777777);
        exp = sb.pop_front();
        checks++;
        if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
            failures++;
            $display("FAIL reset_in_stall got=%h want=%h", {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (StallCount !== 16'd0 || FlushCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_in_stall_counts got=%0d/%0d want=0/0", StallCount, FlushCount);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h408, 32'h88888888);
        exp = sb.pop_front();
        checks++;
        if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
            failures++;
            $display("FAIL load_after_reset got=%h want=%h", {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
                  $urandom, $urandom);
            exp = sb.pop_front();
            checks++;
            if ({ID_PCAddResult, ID_Instruction, ID_Valid} !== exp) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, {ID_PCAddResult, ID_Instruction, ID_Valid}, exp);
            end
`ifdef IF_ID_PERF_COUNT_EN
            checks++;
            if (StallCount !== m_sc || FlushCount !== m_fc) begin
                failures++;
                $display("FAIL b2b_counts[%0d] got=%0d/%0d want=%0d/%0d", i, StallCount, FlushCount, m_sc, m_fc);
            end
`endif
        end
    endtask

`ifdef IF_ID_PERF_COUNT_EN
    task automatic test_saturation();
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        void'(sb.pop_front());
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h500, 32'h99999999);
            void'(sb.pop_front());
            checks++;
            if (StallCount4 !== m_sc4) begin
                failures++;
                $display("FAIL sat_stall[%0d] got=%h want=%h", i, StallCount4, m_sc4);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_bubble_stall();
        test_reset_in_stall();
        test_back_to_back();
`ifdef IF_ID_PERF_COUNT_EN
        test_saturation();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
